// File: rtl/bird_pkg.sv
// Shared types and screen constants for the bird motion engines.
// Positions are fixed-point with FIXED_POINT_SHIFT fractional bits.
package bird_pkg;

    typedef enum logic [1:0] {
        READY_ST   = 2'd0,
        FLIGHT_ST  = 2'd1,
        MOVE_ST    = 2'd2,
        STOPPED_ST = 2'd3
    } state_t;

    localparam int FIXED_POINT_SHIFT = 6;
    localparam int SCREEN_W          = 640;
    localparam int SCREEN_H          = 480;

    // Arithmetic shift floors toward -inf so off-screen-left positions stay negative.
    function automatic logic signed [31:0] to_pixel(input logic signed [31:0] pos);
        return pos >>> FIXED_POINT_SHIFT;
    endfunction

endpackage

// File: rtl/bird_flight.sv
// Per-bird projectile engine: launch on shoot, one fixed-point step per frame, freeze on hit/exit, re-arm after a hold.
// Position updates appear two cycles after startOfFrame; inputs are pulses and are never queued or stalled.
module bird_flight
    import bird_pkg::*;
#(
    parameter int INITIAL_X       = 80,
    parameter int INITIAL_Y       = 360,
    parameter int INITIAL_X_SPEED = 120,
    parameter int INITIAL_Y_SPEED = -250,
    parameter int GRAVITY         = 8,
    parameter int MAX_Y_SPEED     = 400,
    parameter int HOLD_FRAMES     = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        shoot,
    input  logic        startOfFrame,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        in_flight,
    output logic        bird_done
);

    localparam logic signed [31:0] X_INIT    = 32'(INITIAL_X <<< FIXED_POINT_SHIFT);
    localparam logic signed [31:0] Y_INIT    = 32'(INITIAL_Y <<< FIXED_POINT_SHIFT);
    localparam logic signed [31:0] X_SPD0    = 32'(INITIAL_X_SPEED);
    localparam logic signed [31:0] Y_SPD0    = 32'(INITIAL_Y_SPEED);
    localparam logic signed [31:0] GRAV      = 32'(GRAVITY);
    localparam logic signed [31:0] Y_SPD_MAX = 32'(MAX_Y_SPEED);
    localparam logic signed [31:0] X_LIMIT   = 32'(SCREEN_W - 1);
    localparam logic signed [31:0] Y_LIMIT   = 32'(SCREEN_H - 1);
    localparam logic [15:0]        HOLD_LAST = 16'(HOLD_FRAMES - 1);

    state_t             state_q, state_d;
    logic signed [31:0] xpos_q, xpos_d;
    logic signed [31:0] ypos_q, ypos_d;
    logic signed [31:0] xspd_q, xspd_d;
    logic signed [31:0] yspd_q, yspd_d;
    logic               hit_q, hit_d;
    logic [15:0]        hold_cnt_q, hold_cnt_d;
    logic               done_q, done_d;

    logic signed [31:0] xpos_new, ypos_new, yspd_inc;
    logic signed [31:0] new_px, new_py;
    logic               off_screen;

    always_comb begin
        xpos_new   = xpos_q + xspd_q;
        ypos_new   = ypos_q + yspd_q;
        yspd_inc   = yspd_q + GRAV;
        new_px     = to_pixel(xpos_new);
        new_py     = to_pixel(ypos_new);
        // Leaving through the top is allowed; the bird can arc back into view.
        off_screen = (new_px < 0) || (new_px > X_LIMIT) || (new_py > Y_LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        xspd_d     = xspd_q;
        yspd_d     = yspd_q;
        hit_d      = hit_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;

        unique case (state_q)
            READY_ST: begin
                xpos_d = X_INIT;
                ypos_d = Y_INIT;
                if (shoot) begin
                    xspd_d  = X_SPD0;
                    yspd_d  = Y_SPD0;
                    hit_d   = 1'b0;
                    state_d = FLIGHT_ST;
                end
            end
            FLIGHT_ST: begin
                if (collision) hit_d = 1'b1;
                if (startOfFrame) begin
                    // A hit in the same cycle as the frame tick still wins over the move.
                    if (hit_q || collision) begin
                        xspd_d  = '0;
                        yspd_d  = '0;
                        hit_d   = 1'b0;
                        state_d = STOPPED_ST;
                    end else begin
                        state_d = MOVE_ST;
                    end
                end
            end
            MOVE_ST: begin
                xpos_d = xpos_new;
                ypos_d = ypos_new;
                yspd_d = (yspd_inc > Y_SPD_MAX) ? Y_SPD_MAX : yspd_inc;
                hit_d  = hit_q | collision;
                if (off_screen) begin
                    xspd_d  = '0;
                    yspd_d  = '0;
                    hit_d   = 1'b0;
                    state_d = STOPPED_ST;
                end else begin
                    state_d = FLIGHT_ST;
                end
            end
            STOPPED_ST: begin
                if (startOfFrame) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        xpos_d     = X_INIT;
                        ypos_d     = Y_INIT;
                        done_d     = 1'b1;
                        state_d    = READY_ST;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = READY_ST;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= READY_ST;
            xpos_q     <= X_INIT;
            ypos_q     <= Y_INIT;
            xspd_q     <= '0;
            yspd_q     <= '0;
            hit_q      <= 1'b0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            xspd_q     <= xspd_d;
            yspd_q     <= yspd_d;
            hit_q      <= hit_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
        end
    end

    assign topLeftX  = 11'(to_pixel(xpos_q));
    assign topLeftY  = 11'(to_pixel(ypos_q));
    assign in_flight = (state_q == FLIGHT_ST) || (state_q == MOVE_ST);
    assign bird_done = done_q;

endmodule
